uart_channel_sequencer: RTL and testbench

- Controller on the host side of the wide UART I/O block. It shares one host link between NUM_CH client modules (DUT channels).
- Each host packet is one control byte plus WIDTH data bytes. The sequencer latches it, acknowledges it to the UART I/O, and routes it to the channel selected in the control byte.
- It waits for that channel's response, or a timeout, then sends a status byte plus WIDTH data bytes back to the host.
- Only one host transaction is in flight at any time.

---
 rtl/uart_channel_sequencer_pkg.sv | 37 +++
 rtl/uart_resp_select.sv | 26 ++
 rtl/uart_channel_sequencer.sv | 167 ++++++++++++++++
 tb/tb_uart_channel_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_channel_sequencer_pkg.sv
// Shared definitions for the host-side UART channel sequencer: FSM encoding,
// control/status byte field positions and small field helpers.
package uart_channel_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DISPATCH  = 3'd1,
        WAIT_RESP = 3'd2,
        SEND      = 3'd3,
        WAIT_TX   = 3'd4
    } seq_state_e;

    localparam int unsigned CTRL_CH_LSB  = 0;
    localparam int unsigned CTRL_CH_MSB  = 3;
    localparam int unsigned CTRL_OP_LSB  = 4;
    localparam int unsigned CTRL_OP_MSB  = 7;

    localparam int unsigned STAT_BADCH   = 7;
    localparam int unsigned STAT_TIMEOUT = 6;
    localparam int unsigned STAT_CH_MSB  = 3;

    function automatic logic ch_in_range(input logic [3:0] ch, input int unsigned num_ch);
        return {28'd0, ch} < num_ch;
    endfunction

    // Bits [5:4] of the status byte are always zero.
    function automatic logic [7:0] make_status(input logic badch, input logic tmo,
                                               input logic [3:0] ch);
        logic [7:0] s;
        s = '0;
        s[STAT_BADCH]      = badch;
        s[STAT_TIMEOUT]    = tmo;
        s[STAT_CH_MSB:0]   = ch;
        return s;
    endfunction

endpackage

// File: rtl/uart_resp_select.sv
// Combinational NUM_CH:1 response slice mux plus one-hot decode of the channel id.
module uart_resp_select
    import uart_channel_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_CH = 3
) (
    input  logic [3:0]                  ch_i,
    input  logic [NUM_CH*WIDTH*8-1:0]   resp_data_i,
    output logic [WIDTH*8-1:0]          data_o,
    output logic [NUM_CH-1:0]           onehot_o
);

    // Out-of-range ids decode to no channel and zero data.
    always_comb begin
        data_o   = '0;
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_i == 4'(i)) begin
                onehot_o[i] = 1'b1;
                data_o      = resp_data_i[i*WIDTH*8 +: WIDTH*8];
            end
        end
    end

endmodule

// File: rtl/uart_channel_sequencer.sv
// Host-side sequencer: latches one UART host packet, routes it to a client
// channel, waits for its response or a timeout, then returns status + data.
module uart_channel_sequencer
    import uart_channel_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                        masterClock,
    input  logic                        reset,
    input  logic [7:0]                  uioControl,
    input  logic [WIDTH*8-1:0]          uioInputData,
    input  logic                        uioDataReceived,
    output logic                        uioClearDR,
    output logic                        uioTransmit,
    input  logic                        uioTransmitting,
    output logic [7:0]                  uioStatus,
    output logic [WIDTH*8-1:0]          uioOutputData,
    output logic [NUM_CH-1:0]           cmdValid,
    input  logic [NUM_CH-1:0]           cmdReady,
    output logic [3:0]                  cmdOp,
    output logic [WIDTH*8-1:0]          cmdData,
    input  logic [NUM_CH-1:0]           respValid,
    output logic [NUM_CH-1:0]           respReady,
    input  logic [NUM_CH*WIDTH*8-1:0]   respData,
    output logic                        busy
);

    // One spare count above TIMEOUT_CYCLES so the >= compare cannot wrap
    // when a handshake wins the race against the timeout.
    localparam int unsigned    TW     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [TW-1:0]  TO_VAL = TW'(TIMEOUT_CYCLES);

    seq_state_e             state_q;
    logic [TW-1:0]          timer_q;
    logic [3:0]             ch_q;
    logic                   clear_q;
    logic                   transmit_q;
    logic [7:0]             status_q;
    logic [WIDTH*8-1:0]     odata_q;
    logic [NUM_CH-1:0]      cmd_valid_q;
    logic [3:0]             op_q;
    logic [WIDTH*8-1:0]     cdata_q;
    logic [NUM_CH-1:0]      resp_ready_q;

    logic [3:0]             ctrl_ch;
    logic [3:0]             ctrl_op;
    logic [TW-1:0]          timer_d;
    logic [NUM_CH-1:0]      ch_onehot;
    logic [WIDTH*8-1:0]     sel_data;
    logic                   cmd_fire;
    logic                   resp_fire;
    logic                   timeout_hit;

    uart_resp_select #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) u_resp_select (
        .ch_i        (ch_q),
        .resp_data_i (respData),
        .data_o      (sel_data),
        .onehot_o    (ch_onehot)
    );

    assign ctrl_ch     = uioControl[CTRL_CH_MSB:CTRL_CH_LSB];
    assign ctrl_op     = uioControl[CTRL_OP_MSB:CTRL_OP_LSB];
    assign timer_d     = timer_q + TW'(1);
    assign cmd_fire    = |(cmd_valid_q & cmdReady & ch_onehot);
    assign resp_fire   = |(respValid & resp_ready_q & ch_onehot);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_d >= TO_VAL);

    always_ff @(posedge masterClock) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            ch_q         <= '0;
            clear_q      <= 1'b0;
            transmit_q   <= 1'b0;
            status_q     <= '0;
            odata_q      <= '0;
            cmd_valid_q  <= '0;
            op_q         <= '0;
            cdata_q      <= '0;
            resp_ready_q <= '1;
        end else begin
            clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    resp_ready_q <= '1;
                    if (uioDataReceived) begin
                        ch_q         <= ctrl_ch;
                        op_q         <= ctrl_op;
                        cdata_q      <= uioInputData;
                        clear_q      <= 1'b1;
                        timer_q      <= '0;
                        odata_q      <= '0;
                        resp_ready_q <= '0;
                        if (ch_in_range(ctrl_ch, NUM_CH)) begin
                            status_q <= make_status(1'b0, 1'b0, ctrl_ch);
                            state_q  <= DISPATCH;
                        end else begin
                            status_q <= make_status(1'b1, 1'b0, ctrl_ch);
                            state_q  <= SEND;
                        end
                    end
                end
                DISPATCH: begin
                    timer_q <= timer_d;
                    if (cmd_fire) begin
                        cmd_valid_q  <= '0;
                        resp_ready_q <= ch_onehot;
                        state_q      <= WAIT_RESP;
                    end else if (timeout_hit) begin
                        cmd_valid_q            <= '0;
                        status_q[STAT_TIMEOUT] <= 1'b1;
                        transmit_q             <= 1'b1;
                        state_q                <= SEND;
                    end else begin
                        cmd_valid_q <= ch_onehot;
                    end
                end
                WAIT_RESP: begin
                    timer_q <= timer_d;
                    if (resp_fire) begin
                        odata_q      <= sel_data;
                        resp_ready_q <= '0;
                        transmit_q   <= 1'b1;
                        state_q      <= SEND;
                    end else if (timeout_hit) begin
                        resp_ready_q           <= '0;
                        status_q[STAT_TIMEOUT] <= 1'b1;
                        transmit_q             <= 1'b1;
                        state_q                <= SEND;
                    end
                end
                SEND: begin
                    if (uioTransmitting) begin
                        transmit_q <= 1'b0;
                        state_q    <= WAIT_TX;
                    end else begin
                        transmit_q <= 1'b1;
                    end
                end
                WAIT_TX: begin
                    transmit_q <= 1'b0;
                    if (!uioTransmitting) begin
                        resp_ready_q <= '1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uioClearDR    = clear_q;
    assign uioTransmit   = transmit_q;
    assign uioStatus     = status_q;
    assign uioOutputData = odata_q;
    assign cmdValid      = cmd_valid_q;
    assign cmdOp         = op_q;
    assign cmdData       = cdata_q;
    assign respReady     = resp_ready_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_channel_sequencer.sv
// Scoreboard bench for uart_channel_sequencer: directed packets push expected
// status/data; a monitor pops and compares on each new transmit request.
module tb_uart_channel_sequencer;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int TO = 64;

    logic                 masterClock = 1'b0;
    logic                 reset;
    logic [7:0]           uioControl;
    logic [W*8-1:0]       uioInputData;
    logic                 uioDataReceived;
    logic                 uioClearDR;
    logic                 uioTransmit;
    logic                 uioTransmitting;
    logic [7:0]           uioStatus;
    logic [W*8-1:0]       uioOutputData;
    logic [N-1:0]         cmdValid;
    logic [N-1:0]         cmdReady;
    logic [3:0]           cmdOp;
    logic [W*8-1:0]       cmdData;
    logic [N-1:0]         respValid;
    logic [N-1:0]         respReady;
    logic [N*W*8-1:0]     respData;
    logic                 busy;

    uart_channel_sequencer #(
        .WIDTH          (W),
        .NUM_CH         (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .masterClock     (masterClock),
        .reset           (reset),
        .uioControl      (uioControl),
        .uioInputData    (uioInputData),
        .uioDataReceived (uioDataReceived),
        .uioClearDR      (uioClearDR),
        .uioTransmit     (uioTransmit),
        .uioTransmitting (uioTransmitting),
        .uioStatus       (uioStatus),
        .uioOutputData   (uioOutputData),
        .cmdValid        (cmdValid),
        .cmdReady        (cmdReady),
        .cmdOp           (cmdOp),
        .cmdData         (cmdData),
        .respValid       (respValid),
        .respReady       (respReady),
        .respData        (respData),
        .busy            (busy)
    );

    always #5 masterClock = ~masterClock;

    typedef struct packed {
        logic [7:0]  st;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tx_falls = 0;
    int   lat_cyc  = 0;
    int   cv_cnt[N];
    logic tx_prev  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [31:0] d);
        int n = 0;
        @(negedge masterClock);
        uioControl      = c;
        uioInputData    = d;
        uioDataReceived = 1'b1;
        do begin
            @(negedge masterClock);
            n++;
        end while (!uioClearDR && n < 500);
        chk("clear_seen", uioClearDR, 1);
        lat_cyc = cyc;
        uioDataReceived = 1'b0;
    endtask

    task automatic respond(input int ch, input logic [31:0] d);
        int n = 0;
        while (!(busy && respReady == (3'b001 << ch)) && n < 500) begin
            @(negedge masterClock);
            n++;
        end
        chk("rready_onehot", respReady, 3'b001 << ch);
        respValid[ch]         = 1'b1;
        respData[ch*32 +: 32] = d;
        @(negedge masterClock);
        respValid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge masterClock);
            n++;
        end
        chk("reach_idle", busy, 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_outs"}, {uioClearDR, uioTransmit, busy, uioStatus, cmdValid, cmdOp}, 0);
        chk({nm, "_data"}, {uioOutputData, cmdData}, 0);
        chk({nm, "_rready"}, respReady, 3'b111);
    endtask

    initial begin
        int c0;
        int n;
        for (int i = 0; i < N; i++) cv_cnt[i] = 0;
        reset           = 1'b1;
        uioControl      = '0;
        uioInputData    = '0;
        uioDataReceived = 1'b0;
        uioTransmitting = 1'b0;
        cmdReady        = '0;
        respValid       = '0;
        respData        = '0;

        fork
            forever begin
                @(posedge masterClock);
                cyc++;
            end
            begin : uart_model
                int tx_cnt = 0;
                forever begin
                    @(posedge masterClock);
                    #1;
                    if (tx_cnt > 0) begin
                        tx_cnt--;
                        if (tx_cnt == 0) begin
                            uioTransmitting = 1'b0;
                            tx_falls++;
                        end
                    end else if (uioTransmit) begin
                        uioTransmitting = 1'b1;
                        tx_cnt = 3;
                    end
                end
            end
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge masterClock);
                    for (int i = 0; i < N; i++) if (cmdValid[i]) cv_cnt[i]++;
                    if (!reset && uioTransmit && !tx_prev) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_tx", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("tx_status", uioStatus, e.st);
                            chk("tx_data", uioOutputData, e.d);
                        end
                    end
                    tx_prev = uioTransmit;
                end
            end
            begin : watchdog
                #200us;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge masterClock);
        chk_reset_outs("reset");
        reset = 1'b0;
        repeat (2) @(negedge masterClock);

        // T1: normal transaction on channel 1
        cmdReady = 3'b010;
        sb.push_back('{st: 8'h01, d: 32'h12345678});
        c0 = cv_cnt[1];
        send_pkt(8'h51, 32'hDEADBEEF);
        chk("t1_op", cmdOp, 4'h5);
        chk("t1_cdata", cmdData, 32'hDEADBEEF);
        chk("t1_cv_early", cmdValid, 0);
        @(negedge masterClock);
        chk("t1_clr_pulse", uioClearDR, 0);
        chk("t1_cv", cmdValid, 3'b010);
        repeat (5) @(negedge masterClock);
        respond(1, 32'h12345678);
        chk("t1_tx_lat", uioTransmit, 1);
        wait_idle();
        chk("t1_cv_cycles", cv_cnt[1] - c0, 1);

        // T2: invalid channel 7
        sb.push_back('{st: 8'h87, d: 32'h0});
        c0 = cv_cnt[0] + cv_cnt[1] + cv_cnt[2];
        send_pkt(8'h07, 32'h55555555);
        chk("t2_tx_early", uioTransmit, 0);
        @(negedge masterClock);
        chk("t2_tx_lat", uioTransmit, 1);
        wait_idle();
        chk("t2_no_cv", cv_cnt[0] + cv_cnt[1] + cv_cnt[2] - c0, 0);

        // T3: channel 2 accepts command but never responds
        cmdReady = 3'b100;
        sb.push_back('{st: 8'h42, d: 32'h0});
        c0 = cv_cnt[2];
        send_pkt(8'h02, 32'h0BADF00D);
        n = 0;
        while (!uioTransmit && n < 200) begin
            @(negedge masterClock);
            n++;
        end
        chk("t3_to_cycle", cyc - lat_cyc, TO);
        wait_idle();
        chk("t3_cv_cycles", cv_cnt[2] - c0, 1);
        @(negedge masterClock);
        chk("t3_idle_rready", respReady, 3'b111);
        respValid[2]       = 1'b1;
        respData[64 +: 32] = 32'h77777777;
        @(negedge masterClock);
        respValid[2] = 1'b0;
        repeat (5) @(negedge masterClock);
        chk("t3_no_tx", {uioTransmit, busy}, 0);

        // T4: channel 0 stalls command for 10 cycles
        cmdReady = 3'b000;
        sb.push_back('{st: 8'h00, d: 32'hA5A5A5A5});
        c0 = cv_cnt[0];
        send_pkt(8'h00, 32'h13579BDF);
        repeat (11) @(negedge masterClock);
        cmdReady = 3'b001;
        @(negedge masterClock);
        chk("t4_cv_drop", cmdValid, 0);
        respond(0, 32'hA5A5A5A5);
        wait_idle();
        chk("t4_cv_cycles", cv_cnt[0] - c0, 11);

        // T5: reset in WAIT_TX, reset in WAIT_RESP, then a normal packet
        cmdReady = 3'b111;
        sb.push_back('{st: 8'h01, d: 32'h0F0F0F0F});
        send_pkt(8'h01, 32'h0);
        respond(1, 32'h0F0F0F0F);
        n = 0;
        while (!(uioTransmitting && !uioTransmit) && n < 50) begin
            @(negedge masterClock);
            n++;
        end
        chk("t5_in_wait_tx", {busy, uioTransmitting, uioTransmit}, 3'b110);
        reset = 1'b1;
        @(negedge masterClock);
        chk_reset_outs("t5_rst_wtx");
        reset = 1'b0;
        repeat (5) @(negedge masterClock);
        send_pkt(8'h02, 32'h0);
        repeat (4) @(negedge masterClock);
        chk("t5_in_wait_resp", respReady, 3'b100);
        reset = 1'b1;
        @(negedge masterClock);
        chk_reset_outs("t5_rst_wr");
        reset = 1'b0;
        repeat (2) @(negedge masterClock);
        sb.push_back('{st: 8'h01, d: 32'hCAFEF00D});
        send_pkt(8'h31, 32'h24681357);
        chk("t5_op", cmdOp, 4'h3);
        respond(1, 32'hCAFEF00D);
        wait_idle();

        // T6: back-to-back packets, second held until the first transmit ends
        cmdReady = 3'b011;
        sb.push_back('{st: 8'h00, d: 32'h11111111});
        sb.push_back('{st: 8'h01, d: 32'h22222222});
        c0 = tx_falls;
        fork
            begin
                send_pkt(8'h10, 32'hAAAA0000);
                send_pkt(8'h21, 32'hBBBB0000);
                chk("t6_latch_after_txfall", tx_falls - c0, 1);
                chk("t6_op2", cmdOp, 4'h2);
            end
            begin
                respond(0, 32'h11111111);
                respond(1, 32'h22222222);
            end
        join
        wait_idle();
        repeat (3) @(negedge masterClock);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
